// File: rtl/fp_stream_pkg.sv
// Shared definitions for the floating-point result stream: IEEE-754 single
// field positions, the result word type and a NaN classifier.
package fp_stream_pkg;

    localparam int FP_WIDTH = 32;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    typedef logic [FP_WIDTH-1:0] fp_word_t;

    // NaN: exponent all ones with a nonzero mantissa; infinity is not a NaN.
    function automatic logic fp_is_nan(input fp_word_t w);
        return (&w[EXP_MSB:EXP_LSB]) && (|w[MAN_MSB:0]);
    endfunction

endpackage

// File: rtl/sink_fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one write port and an enabled, registered
// read port that forwards a same-cycle write to the read register.
module sink_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // The read register only moves when enabled, so the head word stays put
    // while the consumer stalls.
    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = (we && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fp_result_sink.sv
// First-word-fall-through sink for the valid-only FP result stream, with a
// sticky overflow flag; NaN flagging is enabled by FP_RESULT_SINK_NAN_CHECK_EN.
module fp_result_sink
    import fp_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                   clkIn,
    input  logic                   rstIn,
    input  logic                   validIn,
    input  logic [DATA_WIDTH-1:0]  dataIn,
    output logic [DATA_WIDTH-1:0]  dataOut,
    output logic                   validOut,
    input  logic                   readyIn,
    output logic [$clog2(DEPTH):0] levelOut,
    input  logic                   clearIn,
    output logic                   errorOut,
    output logic                   nanOut
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t          wr_ptr_q, wr_ptr_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    logic          error_q, error_d;
    logic          empty, full, push, pop, drop, rd_en;
    logic [AW-1:0] rd_addr;

    // A pop frees a slot, so a full FIFO still accepts a beat in the same cycle.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = !empty && readyIn;
        push     = validIn && (!full || pop);
        drop     = validIn && !push;
        wr_ptr_d = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        rd_en    = pop || (push && empty);
        rd_addr  = rd_ptr_d[AW-1:0];
        error_d  = drop | (error_q & ~clearIn);
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            error_q  <= error_d;
        end
    end

    sink_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk    (clkIn),
        .rst    (rstIn),
        .we     (push),
        .wr_addr(wr_ptr_q[AW-1:0]),
        .wr_data(dataIn),
        .re     (rd_en),
        .rd_addr(rd_addr),
        .rd_data(dataOut)
    );

`ifdef FP_RESULT_SINK_NAN_CHECK_EN
    logic nan_q, nan_d;

    always_comb begin
        nan_d = (push && fp_is_nan(fp_word_t'(dataIn))) | (nan_q & ~clearIn);
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            nan_q <= 1'b0;
        end else begin
            nan_q <= nan_d;
        end
    end

    assign nanOut = nan_q;
`else
    assign nanOut = 1'b0;
`endif

    assign validOut = !empty;
    assign levelOut = wr_ptr_q - rd_ptr_q;
    assign errorOut = error_q;

endmodule

// File: doc/fp_result_sink.md
# fp_result_sink

Receiving end of the valid-only result stream produced by the floating-point arithmetic units (e.g. `floating_point_add`). It captures every `validIn`/`dataIn` beat into a first-word-fall-through FIFO and re-presents the results on a ready/valid read port for a downstream consumer such as a bus interface or host readback path. The upstream stream has no backpressure, so the block detects beats it had to drop and flags them with a sticky error.

## Interface
Parameters:
- `DATA_WIDTH`, 32: result word width; IEEE-754 single.
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.

Ports:
- `clkIn`, input, 1: clock; all logic on the rising edge.
- `rstIn`, input, 1: reset; asynchronous, active-high.
- `validIn`, input, 1: upstream result beat present this cycle.
- `dataIn`, input, DATA_WIDTH: upstream result word.
- `dataOut`, output, DATA_WIDTH: FIFO head word.
- `validOut`, output, 1: `dataOut` holds a valid entry.
- `readyIn`, input, 1: consumer accepts the head entry.
- `levelOut`, output, clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `clearIn`, input, 1: synchronous clear of the sticky flags.
- `errorOut`, output, 1: sticky overflow flag; a beat was dropped.
- `nanOut`, output, 1: sticky flag; a NaN result was captured. Only active with the macro in Configuration.

## Operation
- Push: `validIn` high, and either the FIFO is not full or a pop happens in the same cycle. The word is written at the write pointer and the write pointer increments.
- Pop: `validOut && readyIn`. The read pointer increments.
- Both pointers are clog2(DEPTH)+1 bits wide and wrap naturally. Full and empty are derived from MSB inequality with equal low bits. `levelOut` equals `wrPtr - rdPtr`, modulo 2^(clog2(DEPTH)+1).
- Full, with push and pop in the same cycle: both succeed and the level is unchanged.
- Empty, with a push: the word is not bypassed. It appears on the next cycle.
- Full, with push and no pop: the beat is dropped, pointers are unchanged, and `errorOut` sets.
- `readyIn` while empty: ignored; no pointer change.
- `clearIn` clears `errorOut` and `nanOut`. If a set condition occurs in the same cycle, set wins.
- Reset mid-operation: pointers and flags return to zero immediately. Stored contents are discarded; RAM contents need no reset.

## Timing
- Reset values: `validOut`=0, `dataOut`=0, `levelOut`=0, `errorOut`=0, `nanOut`=0.
- Push-to-output latency is 1 cycle. A beat accepted at edge N gives `validOut`=1 and `dataOut`=word after edge N, if the FIFO was empty.
- `dataOut` is registered and updates only on a pop or on the first push into an empty FIFO. It holds stable while `validOut && !readyIn`.
- `levelOut` and the flags are registered and update on the same edge as the causing event.
- Sustained throughput is one push and one pop per cycle indefinitely.

## Configuration
- Macro `FP_RESULT_SINK_NAN_CHECK_EN`.
- **Defined:** each accepted beat is tested for NaN. NaN means exponent all ones and mantissa nonzero. A NaN sets `nanOut` on the accept edge. Dropped beats do not set it.
- **Undefined:** `nanOut` is tied to 0 and no NaN logic is synthesized. The port is still present.

## Structure
- Shared package `fp_stream_pkg` holds:
  - `FP_WIDTH`, `EXP_MSB`, `EXP_LSB`, `MAN_MSB`;
  - the `fp_word_t` typedef;
  - the `fp_is_nan()` function, which the arithmetic units reuse.
- One sub-module, `sink_fifo_mem`: a DEPTH×DATA_WIDTH storage array with one write port and a registered read port.
- Pointer, flag and output logic stay in `fp_result_sink`.

## Test plan
- **Reset then single beat:** push 0x3F800000 with `readyIn`=0. One cycle later, `validOut`=1, `dataOut`=0x3F800000, `levelOut`=1.
- **Fill:** 16 consecutive beats 0x00000001..0x00000010 with `readyIn`=0 give `levelOut`=16. A 17th beat 0x40000000 is dropped: `errorOut`=1 and `levelOut` stays 16. Draining returns 0x01..0x10 in order.
- **Full with simultaneous push/pop:** the 17th beat is accepted, `levelOut` stays 16, `errorOut` stays 0, and the last drained word is 0x40000000.
- **Streaming:** 100 beats with `readyIn`=1 throughout. Every word emerges exactly 1 cycle later, in order, and `levelOut` never exceeds 1.
- **Clear vs set:** with `errorOut`=1, pulse `clearIn` while pushing into a full FIFO with no pop. `errorOut` stays 1. A later `clearIn` alone clears it.
- **NaN check (macro defined):** push 0x7FC00000 and `nanOut`=1. Push 0x7F800000 (infinity) after clear and `nanOut` stays 0. With the macro undefined, `nanOut`=0 throughout.
